llsc_monitor: RTL
=================

# llsc_monitor

Link-bit and reservation tracker for the MEM/WB boundary of the five-stage core. It holds the LLbit and the linked word address, and decides SC success combinationally in the MEM stage. When SC fails, it gates the data-RAM write enable. LLbit updates are committed one cycle later (WB), with forwarding of the in-flight update back to a younger SC. The MEM stage drives its inputs; its outputs feed the data-RAM write enable, the SC result mux, and CP0 (LLAddr).

## Interface
- ADDR_W, 32, byte-address width; reservation granularity is one word, compared on bits [ADDR_W-1:2]
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush_i  in  1  exception/ERET flush; kills the MEM op this cycle and clears the reservation
- mem_stall_i  in  1  MEM stalled; MEM-stage op is not captured (bubble into WB)
- mem_ll_i  in  1  LL in MEM this cycle
- mem_sc_i  in  1  SC in MEM this cycle
- mem_addr_i  in  ADDR_W  effective address of the MEM-stage op
- mem_we_i  in  1  raw data-RAM write request from MEM
- snoop_we_i  in  1  write by another bus master
- snoop_addr_i  in  ADDR_W  address of that write
- ram_we_o  out  1  gated data-RAM write enable
- sc_success_o  out  1  SC result written to rt (1 = stored)
- llbit_o  out  1  committed LLbit
- ll_addr_o  out  ADDR_W  committed linked address, word-aligned (low 2 bits 0)

## Operation
- Effective LLbit: the pending WB update if it is valid and its write enable is set, else `llbit_q`. The effective address is selected the same way.
- `sc_success_o` = `mem_sc_i & eff_llbit & (mem_addr_i[ADDR_W-1:2] == eff_addr[ADDR_W-1:2]) & ~flush_i`.
- `ram_we_o` = `mem_sc_i ? sc_success_o : (mem_we_i & ~flush_i)`.
- Capture into the pending register at the clock edge, only if `~mem_stall_i & ~flush_i`:
  - LL: set LLbit to 1 and record the word address.
  - SC: clear LLbit (clears on success and on failure).
  - Otherwise: no update.
- Commit: the pending update is written to `llbit_q` / `ll_addr_q` on the next edge.
- Flush: clears `llbit_q` and invalidates any pending update. Flush wins over a commit in the same cycle.
- Snoop, when enabled: a `snoop_we_i` whose word address matches the effective linked address clears `llbit_q` and clears a pending LL set.
- An LL captured in the same cycle as a snoop is applied after the snoop, so the LL's reservation survives.
- An ordinary store by this core does not affect the reservation.
- LL with `mem_ll_i` and `mem_sc_i` both high: illegal; SC takes priority.

## Timing
- Reset values:
  - `llbit_q` = 0, `ll_addr_q` = 0, pending invalid.
  - Outputs: `llbit_o` 0, `ll_addr_o` 0, `sc_success_o` 0, `ram_we_o` 0.
- `sc_success_o` and `ram_we_o` are combinational, with 0-cycle latency from the MEM inputs.
- Pipeline for LL in MEM at cycle N:
  - Pending update is valid in cycle N+1.
  - `llbit_o` = 1 from N+2.
  - An SC in MEM at N+1 sees the forwarded value.
- Back-to-back SC at N and N+1 to the linked word: the first succeeds; the second sees the forwarded clear and fails.
- Reset asserted mid-sequence: state clears immediately (asynchronous); the first SC after reset fails.
- Stall: pending still commits while stalled; a stalled SC does not re-capture.

## Configuration
- `LLSC_SNOOP_EN` defined: snoop comparison and clear are active as described.
- Undefined: `snoop_we_i` and `snoop_addr_i` are present but ignored. The reservation is cleared only by SC, flush and reset.

## Structure
- The shared defines package holds:
  - `LLBIT_RESET` (0)
  - word-address slice constants
  - the enable/disable constants used for `ram_we_o`
- One sub-module, `llsc_wb_reg`: the pending MEM/WB update register (valid, we, value, addr) with flush and stall handling. Forwarding and gating stay in the top.

## Test plan
- Plain pass: LL 0x0 (memory holds 0x1234), SC 0x0 with rt = 0x5678 → `sc_success_o` = 1, `ram_we_o` = 1, memory becomes 0x5678, `llbit_o` = 0 two cycles later.
- Reservation already consumed: a second SC 0x0 with no intervening LL → `sc_success_o` = 0, `ram_we_o` = 0, memory keeps 0x5678, rt = 0.
- Forwarding: LL 0x0 immediately followed by SC 0x0 (cycle N+1) → success; LL, SC, SC back to back → 1, then 0.
- Address mismatch: LL 0x0, SC 0x4 → fail, 0x4 unchanged. LL 0x0, SC 0x2 → success (same word).
- Flush: LL 0x0, `flush_i` pulse during the LL's WB cycle, then SC 0x0 → fail. Async reset between LL and SC → fail, `llbit_o` = 0 immediately.
- Snoop (with `LLSC_SNOOP_EN`): LL 0x8, snoop write 0x8 → SC fails. Snoop write 0xC → SC succeeds. Without the macro, snoop 0x8 → SC succeeds.

Source files
------------

// File: rtl/llsc_monitor_pkg.sv
// llsc_monitor_pkg: shared constants and types for the LL/SC reservation
// tracker (LLbit reset value, word-address slice, RAM write-enable levels,
// MEM-stage operation decode).
package llsc_monitor_pkg;

  localparam int   ADDR_W_DEF  = 32;
  localparam int   WORD_LSB    = 2;
  localparam logic LLBIT_RESET = 1'b0;
  localparam logic RAM_WE_EN   = 1'b1;
  localparam logic RAM_WE_DIS  = 1'b0;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_LL   = 2'd1,
    OP_SC   = 2'd2
  } mem_op_e;

  // SC wins when LL and SC are both (illegally) raised together
  function automatic mem_op_e decode_op(input logic ll, input logic sc);
    if (sc)      return OP_SC;
    else if (ll) return OP_LL;
    else         return OP_NONE;
  endfunction

endpackage

// File: rtl/llsc_monitor_if.sv
// llsc_monitor_if: MEM-stage side of the LL/SC monitor. The master is the
// MEM stage (plus the bus snoop source); the slave is the monitor.
interface llsc_monitor_if #(parameter int ADDR_W = 32);

  logic              flush_i;
  logic              mem_stall_i;
  logic              mem_ll_i;
  logic              mem_sc_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic              mem_we_i;
  logic              snoop_we_i;
  logic [ADDR_W-1:0] snoop_addr_i;
  logic              ram_we_o;
  logic              sc_success_o;
  logic              llbit_o;
  logic [ADDR_W-1:0] ll_addr_o;

  modport master (
    output flush_i, mem_stall_i, mem_ll_i, mem_sc_i, mem_addr_i, mem_we_i,
           snoop_we_i, snoop_addr_i,
    input  ram_we_o, sc_success_o, llbit_o, ll_addr_o
  );

  modport slave (
    input  flush_i, mem_stall_i, mem_ll_i, mem_sc_i, mem_addr_i, mem_we_i,
           snoop_we_i, snoop_addr_i,
    output ram_we_o, sc_success_o, llbit_o, ll_addr_o
  );

endinterface

// File: rtl/llsc_wb_reg.sv
// llsc_wb_reg: pending MEM/WB LLbit update. Holds the update for exactly one
// cycle; a stall or flush puts a bubble into WB instead of capturing.
module llsc_wb_reg
  import llsc_monitor_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  mem_op_e           op,
  input  logic [ADDR_W-1:0] ll_addr,
  input  logic [ADDR_W-1:0] keep_addr,
  output logic              pend_valid,
  output logic              pend_we,
  output logic              pend_value,
  output logic [ADDR_W-1:0] pend_addr
);

  // Capture the MEM op's LLbit effect; an SC keeps the current linked address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_we    <= 1'b0;
      pend_value <= LLBIT_RESET;
      pend_addr  <= '0;
    end else if (flush || stall) begin
      pend_valid <= 1'b0;
      pend_we    <= 1'b0;
    end else begin
      pend_valid <= 1'b1;
      pend_we    <= (op != OP_NONE);
      pend_value <= (op == OP_LL);
      pend_addr  <= (op == OP_LL) ? ll_addr : keep_addr;
    end
  end

endmodule

// File: rtl/llsc_monitor.sv
// llsc_monitor: LLbit / linked-address tracker at the MEM/WB boundary.
// SC success and the gated RAM write enable are combinational in MEM; the
// LLbit update commits one cycle later, with forwarding to a younger SC.
// Optional feature: define LLSC_SNOOP_EN to let foreign bus writes to the
// linked word break the reservation.
module llsc_monitor
  import llsc_monitor_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic          clk,
  input logic          rst,
  llsc_monitor_if.slave bus
);

  logic              llbit_q;
  logic [ADDR_W-1:0] ll_addr_q;
  logic              pend_valid;
  logic              pend_we;
  logic              pend_value;
  logic [ADDR_W-1:0] pend_addr;
  logic              fwd;
  logic              eff_llbit;
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] mem_word_addr;
  logic              addr_match;
  logic              sc_success;
  logic              snoop_hit;
  mem_op_e           op;

  assign op            = decode_op(bus.mem_ll_i, bus.mem_sc_i);
  assign mem_word_addr = {bus.mem_addr_i[ADDR_W-1:WORD_LSB], {WORD_LSB{1'b0}}};
  assign fwd           = pend_valid & pend_we;
  assign eff_llbit     = fwd ? pend_value : llbit_q;
  assign eff_addr      = fwd ? pend_addr  : ll_addr_q;
  assign addr_match    = (bus.mem_addr_i[ADDR_W-1:WORD_LSB] == eff_addr[ADDR_W-1:WORD_LSB]);
  assign sc_success    = bus.mem_sc_i & eff_llbit & addr_match & ~bus.flush_i;

`ifdef LLSC_SNOOP_EN
  logic unused_snoop_low;
  assign snoop_hit = bus.snoop_we_i &
                     (bus.snoop_addr_i[ADDR_W-1:WORD_LSB] == eff_addr[ADDR_W-1:WORD_LSB]);
  assign unused_snoop_low = ^bus.snoop_addr_i[WORD_LSB-1:0];
`else
  logic unused_snoop;
  assign snoop_hit    = 1'b0;
  assign unused_snoop = ^{bus.snoop_we_i, bus.snoop_addr_i};
`endif

  assign bus.sc_success_o = sc_success;
  assign bus.ram_we_o     = bus.mem_sc_i ? (sc_success ? RAM_WE_EN : RAM_WE_DIS)
                                         : ((bus.mem_we_i & ~bus.flush_i) ? RAM_WE_EN : RAM_WE_DIS);
  assign bus.llbit_o      = llbit_q;
  assign bus.ll_addr_o    = ll_addr_q;

  llsc_wb_reg #(.ADDR_W(ADDR_W)) u_wb_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush_i),
    .stall      (bus.mem_stall_i),
    .op         (op),
    .ll_addr    (mem_word_addr),
    .keep_addr  (eff_addr),
    .pend_valid (pend_valid),
    .pend_we    (pend_we),
    .pend_value (pend_value),
    .pend_addr  (pend_addr)
  );

  // Commit the WB update; flush beats commit, a snoop hit masks an LL set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      llbit_q   <= LLBIT_RESET;
      ll_addr_q <= '0;
    end else if (bus.flush_i) begin
      llbit_q   <= 1'b0;
    end else if (fwd) begin
      llbit_q   <= pend_value & ~snoop_hit;
      ll_addr_q <= pend_addr;
    end else if (snoop_hit) begin
      llbit_q   <= 1'b0;
    end
  end

endmodule
